arrow_note_engine: RTL

Gameplay core of the dance-arrow VGA demo. Spawns arrows into four lanes from an LFSR, scrolls them upward at a fixed step rate and judges button presses against the target row. It also tracks score, misses and game state. It sits directly upstream of the VGA renderer: the renderer draws each active slot at column(lane), slot_y, and drives LEDs and SSD from score, misses and state.

---
 rtl/arrow_note_engine.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/arrow_note_engine.sv
// rtl/arrow_note_engine.sv - arrow spawn/scroll/judge core for the dance-arrow VGA demo
module arrow_note_engine #(
    parameter int TICK_DIV  = 2_000_000,
    parameter int STEP      = 6,
    parameter int SPAWN_Y   = 470,
    parameter int Y_TARGET  = 40,
    parameter int HIT_WIN   = 10,
    parameter int SPAWN_GAP = 4,
    parameter int WIN_SCORE = 10,
    parameter int MAX_MISS  = 8
) (
    input  logic        board_clk,
    input  logic        reset,
    input  logic        start,
    input  logic        btn_l,
    input  logic        btn_u,
    input  logic        btn_r,
    input  logic        btn_d,
    output logic [7:0]  slot_valid,
    output logic [15:0] slot_lane,
    output logic [79:0] slot_y,
    output logic [3:0]  score,
    output logic [3:0]  misses,
    output logic [1:0]  state,
    output logic        hit_pulse,
    output logic        miss_pulse
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SPAWN_LAST = SW'(SPAWN_GAP - 1);
    localparam logic [10:0]   WIN_LO     = 11'(Y_TARGET - HIT_WIN);
    localparam logic [10:0]   WIN_HI     = 11'(Y_TARGET + HIT_WIN);
    localparam logic [10:0]   RETIRE_Y   = 11'(Y_TARGET - HIT_WIN + STEP);
    localparam logic [9:0]    STEP_V     = 10'(STEP);
    localparam logic [9:0]    SPAWN_V    = 10'(SPAWN_Y);
    localparam logic [15:0]   LFSR_SEED  = 16'hACE1;

    typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, DONE = 2'b10} state_t;

    state_t          st;
    logic [7:0]      valid_r;
    logic [1:0]      lane_r [8];
    logic [9:0]      y_r    [8];
    logic [TW-1:0]   tick_cnt;
    logic [SW-1:0]   spawn_cnt;
    logic [15:0]     lfsr;
    logic [3:0]      sync1, sync2, sync3;

    logic [3:0]      btn_raw, press;
    logic            step, spawn_now, clear_all;
    logic [15:0]     lfsr_next;
    logic [7:0]      in_window, retire;
    logic [7:0]      nxt_valid, cleared;
    logic [1:0]      nxt_lane [8];
    logic [9:0]      nxt_y    [8];
    logic [2:0]      hit_cnt;
    logic [3:0]      miss_cnt;
    logic            found;
    logic [4:0]      score_sum, miss_sum;

    assign btn_raw   = {btn_d, btn_r, btn_u, btn_l};
    assign press     = sync2 & ~sync3;
    assign step      = (tick_cnt == TICK_LAST);
    assign spawn_now = step && (spawn_cnt == SPAWN_LAST);
    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign clear_all = (st == IDLE) || (st == DONE && !start);
    assign score_sum = {1'b0, score} + {2'b00, hit_cnt};
    assign miss_sum  = {1'b0, misses} + {1'b0, miss_cnt};

    assign slot_valid = valid_r;
    assign state      = st;

    always_comb begin
        slot_lane = '0;
        slot_y    = '0;
        in_window = '0;
        retire    = '0;
        for (int i = 0; i < 8; i++) begin
            slot_lane[2*i +: 2] = lane_r[i];
            slot_y[10*i +: 10]  = y_r[i];
            in_window[i] = ({1'b0, y_r[i]} >= WIN_LO) && ({1'b0, y_r[i]} <= WIN_HI);
            retire[i]    = ({1'b0, y_r[i]} < RETIRE_Y);
        end
    end

    // Presses are judged on pre-step positions; a slot hit this cycle skips the step.
    always_comb begin
        nxt_valid = valid_r;
        nxt_lane  = lane_r;
        nxt_y     = y_r;
        cleared   = '0;
        hit_cnt   = '0;
        miss_cnt  = '0;
        found     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            found = 1'b0;
            if (press[k]) begin
                for (int i = 0; i < 8; i++) begin
                    if (!found && valid_r[i] && lane_r[i] == 2'(k) && in_window[i]) begin
                        found        = 1'b1;
                        nxt_valid[i] = 1'b0;
                        cleared[i]   = 1'b1;
                    end
                end
                if (found) hit_cnt  = hit_cnt + 3'd1;
                else       miss_cnt = miss_cnt + 4'd1;
            end
        end
        if (step) begin
            for (int i = 0; i < 8; i++) begin
                if (valid_r[i] && !cleared[i]) begin
                    if (retire[i]) begin
                        nxt_valid[i] = 1'b0;
                        miss_cnt     = miss_cnt + 4'd1;
                    end else begin
                        nxt_y[i] = y_r[i] - STEP_V;
                    end
                end
            end
            // Free slots are taken from the start-of-cycle occupancy.
            if (spawn_now) begin
                found = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    if (!found && !valid_r[i]) begin
                        found        = 1'b1;
                        nxt_valid[i] = 1'b1;
                        nxt_lane[i]  = lfsr[1:0];
                        nxt_y[i]     = SPAWN_V;
                    end
                end
            end
        end
    end

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            st         <= IDLE;
            valid_r    <= '0;
            lane_r     <= '{default: 2'b00};
            y_r        <= '{default: 10'd0};
            tick_cnt   <= '0;
            spawn_cnt  <= '0;
            lfsr       <= LFSR_SEED;
            score      <= '0;
            misses     <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            sync1      <= '0;
            sync2      <= '0;
            sync3      <= '0;
        end else begin
            sync1      <= btn_raw;
            sync2      <= sync1;
            sync3      <= sync2;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            case (st)
                IDLE:    if (start) st <= PLAY;
                PLAY:    if (score >= 4'(WIN_SCORE) || misses >= 4'(MAX_MISS)) st <= DONE;
                DONE:    if (!start) st <= IDLE;
                default: st <= IDLE;
            endcase
            if (clear_all) begin
                valid_r   <= '0;
                lane_r    <= '{default: 2'b00};
                y_r       <= '{default: 10'd0};
                tick_cnt  <= '0;
                spawn_cnt <= '0;
                lfsr      <= LFSR_SEED;
                score     <= '0;
                misses    <= '0;
            end else if (st == PLAY) begin
                valid_r    <= nxt_valid;
                lane_r     <= nxt_lane;
                y_r        <= nxt_y;
                tick_cnt   <= step ? '0 : tick_cnt + 1'b1;
                score      <= (score_sum > 5'd15) ? 4'hF : score_sum[3:0];
                misses     <= (miss_sum > 5'd15) ? 4'hF : miss_sum[3:0];
                hit_pulse  <= (hit_cnt != 3'd0);
                miss_pulse <= (miss_cnt != 4'd0);
                if (step) spawn_cnt <= spawn_now ? '0 : spawn_cnt + 1'b1;
                if (spawn_now) lfsr <= lfsr_next;
            end
        end
    end

endmodule
